// File: rtl/frame_pixel_scanner.sv
// frame_pixel_scanner
// Raster-scan driver for the renderer chain and write side of the VGA adapter.
// It sweeps x/y across the screen, carries each issued coordinate through a
// delay line that matches the renderer (sprite ROM) latency, and presents the
// re-aligned pixel on the plot/vgaX/vgaY/vgaColor write port. After each frame
// it drains the delay line, then raises frameClk for FRAME_HOLD cycles and
// bumps frameCount.
//
// Ports:
//   clk        system clock, all logic on posedge
//   resetn     asynchronous active-low reset
//   enable     level, high lets SCAN issue a new pixel each cycle
//   color      renderer colour for the coordinate issued PIXEL_LATENCY cycles ago
//   x, y       current scan coordinate driven into the renderers
//   plot       VGA write strobe, one cycle per pixel
//   vgaX, vgaY coordinate of the pixel being written
//   vgaColor   colour of the pixel being written (passthrough of color)
//   frameClk   high during vertical blank
//   frameCount completed-frame counter, wraps modulo 2^16

module frame_pixel_scanner #(
  parameter int SCREEN_W      = 160,
  parameter int SCREEN_H      = 120,
  parameter int PIXEL_LATENCY = 2,
  parameter int FRAME_HOLD    = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic [2:0]  color,
  output logic [7:0]  x,
  output logic [7:0]  y,
  output logic        plot,
  output logic [7:0]  vgaX,
  output logic [7:0]  vgaY,
  output logic [2:0]  vgaColor,
  output logic        frameClk,
  output logic [15:0] frameCount
);

  localparam logic [7:0] X_LAST = 8'(SCREEN_W - 1);
  localparam logic [7:0] Y_LAST = 8'(SCREEN_H - 1);

  // The phase counter times both FLUSH and VBLANK, so size it for the longer one.
  localparam int PHASE_MAX = (PIXEL_LATENCY > FRAME_HOLD) ? PIXEL_LATENCY : FRAME_HOLD;
  localparam int CNT_W     = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(PIXEL_LATENCY - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(FRAME_HOLD - 1);

  typedef enum logic [1:0] {
    SCAN,
    FLUSH,
    VBLANK
  } stateT;

  stateT                    state;
  logic [CNT_W-1:0]         phaseCnt;
  logic                     issue;
  logic [PIXEL_LATENCY-1:0] validPipe;
  logic [7:0]               xPipe [PIXEL_LATENCY];
  logic [7:0]               yPipe [PIXEL_LATENCY];

  assign issue = (state == SCAN) && enable;

  // Scan sequencer: walks x/y in raster order while enabled, then spends
  // PIXEL_LATENCY cycles letting the last pixels drain before vertical blank.
  // x/y are already parked at 0 when the last pixel is issued, so FLUSH and
  // VBLANK never need to touch them.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= SCAN;
      phaseCnt   <= '0;
      x          <= 8'd0;
      y          <= 8'd0;
      frameClk   <= 1'b0;
      frameCount <= 16'd0;
    end else begin
      case (state)
        SCAN: begin
          if (enable) begin
            if (x == X_LAST) begin
              x <= 8'd0;
              if (y == Y_LAST) begin
                y        <= 8'd0;
                state    <= FLUSH;
                phaseCnt <= '0;
              end else begin
                y <= y + 8'd1;
              end
            end else begin
              x <= x + 8'd1;
            end
          end
        end
        FLUSH: begin
          if (phaseCnt == FLUSH_LAST) begin
            state      <= VBLANK;
            phaseCnt   <= '0;
            frameClk   <= 1'b1;
            frameCount <= frameCount + 16'd1;
          end else begin
            phaseCnt <= phaseCnt + 1'b1;
          end
        end
        VBLANK: begin
          if (phaseCnt == HOLD_LAST) begin
            state    <= SCAN;
            phaseCnt <= '0;
            frameClk <= 1'b0;
          end else begin
            phaseCnt <= phaseCnt + 1'b1;
          end
        end
        default: begin
          state    <= SCAN;
          phaseCnt <= '0;
          frameClk <= 1'b0;
        end
      endcase
    end
  end

  // Coordinate delay line: free-running shift register that never stalls, so
  // pixels already in flight keep draining while the scan is paused.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      validPipe <= '0;
      for (int i = 0; i < PIXEL_LATENCY; i++) begin
        xPipe[i] <= 8'd0;
        yPipe[i] <= 8'd0;
      end
    end else begin
      validPipe[0] <= issue;
      xPipe[0]     <= x;
      yPipe[0]     <= y;
      for (int i = 1; i < PIXEL_LATENCY; i++) begin
        validPipe[i] <= validPipe[i-1];
        xPipe[i]     <= xPipe[i-1];
        yPipe[i]     <= yPipe[i-1];
      end
    end
  end

  assign plot     = validPipe[PIXEL_LATENCY-1];
  assign vgaX     = xPipe[PIXEL_LATENCY-1];
  assign vgaY     = yPipe[PIXEL_LATENCY-1];
  assign vgaColor = color;

endmodule

// File: tb/tb_frame_pixel_scanner.sv
// tb_frame_pixel_scanner
// Self-checking bench for frame_pixel_scanner on a 4x3 screen with a 2-cycle
// model ROM driving color = {x[0], y[1:0]}. The reference model tracks the
// frame as a pixel index plus a count of cycles since the last pixel of the
// frame, and logs what was issued each cycle so the expected write port is
// simply the log entry PIXEL_LATENCY cycles back.

module tb_frame_pixel_scanner;

  localparam int W    = 4;
  localparam int H    = 3;
  localparam int L    = 2;
  localparam int HOLD = 3;

  logic        clk;
  logic        resetn;
  logic        enable;
  logic [2:0]  color;
  logic [7:0]  x;
  logic [7:0]  y;
  logic        plot;
  logic [7:0]  vgaX;
  logic [7:0]  vgaY;
  logic [2:0]  vgaColor;
  logic        frameClk;
  logic [15:0] frameCount;

  frame_pixel_scanner #(
    .SCREEN_W(W),
    .SCREEN_H(H),
    .PIXEL_LATENCY(L),
    .FRAME_HOLD(HOLD)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .enable(enable),
    .color(color),
    .x(x),
    .y(y),
    .plot(plot),
    .vgaX(vgaX),
    .vgaY(vgaY),
    .vgaColor(vgaColor),
    .frameClk(frameClk),
    .frameCount(frameCount)
  );

  // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model sprite ROM: two registered stages from the scan coordinate to color.
  logic [2:0] romD1;
  logic [2:0] romD2;
  always @(posedge clk) begin
    romD1 <= {x[0], y[1:0]};
    romD2 <= romD1;
  end
  assign color = romD2;

  // Reference model state
  int          mPix;
  int          mTail;
  logic [15:0] mFrames;
  int          issueLog[$];
  int          testsRun;
  int          testsFailed;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    issueLog.delete();
    mPix    = 0;
    mTail   = 0;
    mFrames = 16'd0;
  endtask

  // One clock edge of the frame model, given the enable level seen at that edge.
  task automatic modelStep(input logic en);
    if (mTail == 0) begin
      if (en) begin
        issueLog.push_back(mPix);
        mPix++;
        if (mPix == W * H) begin
          mPix  = 0;
          mTail = 1;
        end
      end else begin
        issueLog.push_back(-1);
      end
    end else begin
      issueLog.push_back(-1);
      if (mTail == L + HOLD) begin
        mTail = 0;
      end else begin
        mTail++;
        if (mTail == L + 1) mFrames = mFrames + 16'd1;
      end
    end
  endtask

  task automatic checkOutput();
    int e;
    int ex;
    int ey;
    e = (issueLog.size() >= L) ? issueLog[issueLog.size() - L] : -1;
    check("x", 32'(x), 32'(mPix % W));
    check("y", 32'(y), 32'(mPix / W));
    check("plot", 32'(plot), 32'(e >= 0));
    if (e >= 0) begin
      ex = e % W;
      ey = e / W;
      check("vgaX", 32'(vgaX), 32'(ex));
      check("vgaY", 32'(vgaY), 32'(ey));
      check("vgaColor", 32'(vgaColor), 32'({ex[0], ey[1:0]}));
    end
    check("frameClk", 32'(frameClk), 32'(mTail > L));
    check("frameCount", 32'(frameCount), 32'(mFrames));
  endtask

  task automatic applyStimulus(input logic en);
    enable = en;
    @(posedge clk);
    #1;
    modelStep(en);
    checkOutput();
  endtask

  initial begin
    int firstRise;
    int highCount;
    bit reached;

    testsRun    = 0;
    testsFailed = 0;
    resetn      = 1'b0;
    enable      = 1'b0;
    modelReset();

    // Reset state, checked while reset is still asserted
    #12;
    checkOutput();
    #10;
    resetn = 1'b1;

    // Continuous run: three full frames plus a bit
    firstRise = -1;
    for (int i = 0; i < 17 * 3 + 3; i++) begin
      applyStimulus(1'b1);
      if (frameClk === 1'b1 && firstRise < 0) firstRise = i + 1;
    end
    check("frameClk_first_rise_cycle", 32'(firstRise), 32'd14);
    check("frameCount_after_3", 32'(frameCount), 32'd3);

    // Pause right after (1,1) is issued; resume must continue at (2,1)
    reached = 1'b0;
    for (int i = 0; i < 40 && !reached; i++) begin
      applyStimulus(1'b1);
      reached = (mPix == W + 2) && (mTail == 0);
    end
    check("reach_pause_point", 32'(reached), 32'd1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0);
    check("paused_x", 32'(x), 32'd2);
    check("paused_y", 32'(y), 32'd1);

    // enable low through FLUSH and VBLANK: timing unchanged, SCAN waits at (0,0)
    reached = 1'b0;
    for (int i = 0; i < 40 && !reached; i++) begin
      applyStimulus(1'b1);
      reached = (mTail == 1);
    end
    check("reach_flush", 32'(reached), 32'd1);
    highCount = 0;
    for (int i = 0; i < L + HOLD + 4; i++) begin
      applyStimulus(1'b0);
      if (frameClk === 1'b1) highCount++;
    end
    check("frameClk_high_cycles", 32'(highCount), 32'(HOLD));

    // Randomized enable pattern
    for (int i = 0; i < 80; i++) applyStimulus(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);

    // Asynchronous reset mid-line, just after (2,1) is issued
    reached = 1'b0;
    for (int i = 0; i < 60 && !reached; i++) begin
      applyStimulus(1'b1);
      reached = (mPix == W + 3) && (mTail == 0);
    end
    check("reach_reset_point", 32'(reached), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    modelReset();
    checkOutput();
    #20;
    checkOutput();
    resetn = 1'b1;
    for (int i = 0; i < 20; i++) applyStimulus(1'b1);

    // frameCount wrap: preload 16'hFFFF mid-scan, next completion gives 0
    force dut.frameCount = 16'hFFFF;
    #1;
    release dut.frameCount;
    mFrames = 16'hFFFF;
    reached = 1'b0;
    for (int i = 0; i < 40 && !reached; i++) begin
      applyStimulus(1'b1);
      reached = (mTail == L + 1);
    end
    check("reach_wrap", 32'(reached), 32'd1);
    check("frameCount_wrap", 32'(frameCount), 32'd0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
